// File: rtl/usb_rx_unencode_pkg.sv
// Shared constants and types for the USB receive-side decoder.
//   SYNC_PATTERN : decoded SYNC byte, LSB received first
//   STUFF_LIMIT  : run of decoded 1s after which a stuff bit follows
//   rx_state_t   : decoder state machine encoding
package usb_rx_pkg;

   localparam logic [7:0] SYNC_PATTERN = 8'h80;
   localparam logic [2:0] STUFF_LIMIT  = 3'd6;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      DATA,
      DROP
   } rx_state_t;

endpackage

// File: rtl/usb_rx_unencode_if.sv
// Line-side inputs and parser-side outputs of the USB receive decoder.
//   master : DP/DM reader / bench side (drives bstr, bstr_ready, done)
//   slave  : decoder side (drives the byte stream, strobes and status)
interface usb_rx_unencode_if;

   logic       bstr;
   logic       bstr_ready;
   logic       done;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       pkt_start;
   logic       pkt_end;
   logic [6:0] byte_count;
   logic       align_err;
   logic       sync_err;
   logic       stuff_err;

   modport master (
      output bstr, bstr_ready, done,
      input  byte_out, byte_valid, pkt_start, pkt_end,
      input  byte_count, align_err, sync_err, stuff_err
   );

   modport slave (
      input  bstr, bstr_ready, done,
      output byte_out, byte_valid, pkt_start, pkt_end,
      output byte_count, align_err, sync_err, stuff_err
   );

endinterface

// File: rtl/usb_rx_unencode_unstuff.sv
// Two-deep line delay, NRZI decode and bit unstuffing.
//   clk, rst_b  : clock, async active-low reset
//   start       : first sample of a packet; restarts the delay line
//   sample      : line level
//   sample_vld  : sample holds a packet sample
//   flush       : end of packet, discards the two held samples (SE0)
//   rx_bit      : decoded bit being committed
//   bit_valid   : rx_bit is a payload/SYNC bit (stuff bits suppressed)
//   stuff_viol  : a 1 arrived where a stuff bit was required
module rx_unstuff
   import usb_rx_pkg::*;
(
   input  logic clk,
   input  logic rst_b,
   input  logic start,
   input  logic sample,
   input  logic sample_vld,
   input  logic flush,
   output logic rx_bit,
   output logic bit_valid,
   output logic stuff_viol
);

   logic [1:0] dly;
   logic [1:0] dly_vld;
   logic       prev_level;
   logic [2:0] ones_cnt;
   logic       commit;
   logic       decoded;
   logic       is_stuff;

   // The oldest sample is only committed when a newer one pushes it out,
   // which keeps the two trailing SE0 samples from ever being decoded.
   assign commit     = sample_vld & dly_vld[1] & ~start;
   assign decoded    = (dly[1] == prev_level);
   assign is_stuff   = (ones_cnt == STUFF_LIMIT);
   assign rx_bit     = decoded;
   assign bit_valid  = commit & ~is_stuff;
   assign stuff_viol = commit & is_stuff & decoded;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         dly        <= 2'b00;
         dly_vld    <= 2'b00;
         prev_level <= 1'b1;
         ones_cnt   <= 3'd0;
      end else if (start) begin
         dly        <= {1'b0, sample};
         dly_vld    <= 2'b01;
         prev_level <= 1'b1;
         ones_cnt   <= 3'd0;
      end else begin
         if (flush) begin
            dly_vld <= 2'b00;
         end else if (sample_vld) begin
            dly     <= {dly[0], sample};
            dly_vld <= {dly_vld[0], 1'b1};
         end
         // Dropped stuff bits still advance the NRZI reference level.
         if (commit) begin
            prev_level <= dly[1];
            if (!decoded || is_stuff)
               ones_cnt <= 3'd0;
            else
               ones_cnt <= ones_cnt + 3'd1;
         end
      end
   end

endmodule

// File: rtl/usb_rx_unencode.sv
// USB receive decoder: SYNC check, payload deserialisation (LSB first),
// packet boundary and error reporting downstream of the DP/DM reader.
//   MAX_BYTES : byte_count saturation value
//   clk       : one line bit per cycle
//   rst_b     : async active-low reset
//   rx        : slave side of usb_rx_unencode_if (line in, bytes/status out)
//
// state | meaning
// IDLE  | waiting for the first packet sample
// SYNC  | collecting the 8 SYNC bits
// DATA  | assembling payload bytes until EOP
// DROP  | packet rejected, waiting for EOP or abort
module usb_rx_unencode
   import usb_rx_pkg::*;
#(
   parameter int MAX_BYTES = 16
) (
   input  logic             clk,
   input  logic             rst_b,
   usb_rx_unencode_if.slave rx
);

   localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

   rx_state_t  state;
   logic [2:0] bit_idx;
   logic [7:0] shreg;
   logic [7:0] sh_next;
   logic [2:0] idx_next;
   logic       start;
   logic       rx_bit;
   logic       bit_valid;
   logic       stuff_viol;

   logic [7:0] byte_out_q;
   logic [6:0] byte_count_q;
   logic       byte_valid_q, pkt_start_q, pkt_end_q;
   logic       align_err_q, sync_err_q, stuff_err_q;

   assign start    = (state == IDLE) & rx.bstr_ready;
   assign sh_next  = {rx_bit, shreg[7:1]};
   assign idx_next = bit_idx + {2'b00, bit_valid};

   rx_unstuff u_unstuff (
      .clk        (clk),
      .rst_b      (rst_b),
      .start      (start),
      .sample     (rx.bstr),
      .sample_vld (rx.bstr_ready),
      .flush      (rx.done),
      .rx_bit     (rx_bit),
      .bit_valid  (bit_valid),
      .stuff_viol (stuff_viol)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state        <= IDLE;
         bit_idx      <= 3'd0;
         shreg        <= 8'h00;
         byte_out_q   <= 8'h00;
         byte_count_q <= 7'd0;
         byte_valid_q <= 1'b0;
         pkt_start_q  <= 1'b0;
         pkt_end_q    <= 1'b0;
         align_err_q  <= 1'b0;
         sync_err_q   <= 1'b0;
         stuff_err_q  <= 1'b0;
      end else begin
         byte_valid_q <= 1'b0;
         pkt_start_q  <= 1'b0;
         pkt_end_q    <= 1'b0;
         sync_err_q   <= 1'b0;
         stuff_err_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (rx.bstr_ready) begin
                  state   <= SYNC;
                  bit_idx <= 3'd0;
               end
            end
            SYNC: begin
               if (rx.done) begin
                  sync_err_q <= 1'b1;
                  state      <= IDLE;
               end else if (!rx.bstr_ready) begin
                  state <= IDLE;
               end else if (stuff_viol) begin
                  // Seven 1s can never be a valid SYNC.
                  sync_err_q <= 1'b1;
                  state      <= DROP;
               end else if (bit_valid) begin
                  shreg   <= sh_next;
                  bit_idx <= idx_next;
                  if (bit_idx == 3'd7) begin
                     if (sh_next == SYNC_PATTERN) begin
                        pkt_start_q  <= 1'b1;
                        byte_count_q <= 7'd0;
                        align_err_q  <= 1'b0;
                        state        <= DATA;
                     end else begin
                        sync_err_q <= 1'b1;
                        state      <= DROP;
                     end
                  end
               end
            end
            DATA: begin
               if (bit_valid) begin
                  shreg   <= sh_next;
                  bit_idx <= idx_next;
                  if (bit_idx == 3'd7) begin
                     byte_out_q   <= sh_next;
                     byte_valid_q <= 1'b1;
                     if (byte_count_q != MAX_CNT)
                        byte_count_q <= byte_count_q + 7'd1;
                  end
               end
               // A byte finishing alongside done is counted before pkt_end.
               if (stuff_viol) begin
                  stuff_err_q <= 1'b1;
                  state       <= DROP;
               end else if (rx.done) begin
                  pkt_end_q   <= 1'b1;
                  align_err_q <= (idx_next != 3'd0);
                  state       <= IDLE;
               end else if (!rx.bstr_ready) begin
                  state <= IDLE;
               end
            end
            DROP: begin
               if (rx.done || !rx.bstr_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rx.byte_out   = byte_out_q;
   assign rx.byte_valid = byte_valid_q;
   assign rx.pkt_start  = pkt_start_q;
   assign rx.pkt_end    = pkt_end_q;
   assign rx.byte_count = byte_count_q;
   assign rx.align_err  = align_err_q;
   assign rx.sync_err   = sync_err_q;
   assign rx.stuff_err  = stuff_err_q;

endmodule

// File: tb/tb_usb_rx_unencode.sv
// Self-checking bench for usb_rx_unencode. Packets are built as decoded bit
// lists (SYNC, payload with inserted stuff bits, deliberate faults), NRZI
// encoded onto the line, and every output is compared cycle by cycle with
// expectations derived from how each packet was constructed.
module tb_usb_rx_unencode;

   localparam int MAXB = 16;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   always #5 clk = ~clk;

   usb_rx_unencode_if rx();

   usb_rx_unencode #(.MAX_BYTES(MAXB)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .rx    (rx)
   );

   int total = 0;
   int bad   = 0;

   // kind: 0 sync, 1 payload, 2 stuff, 3 stuff violation, 4 ignored
   bit dec[$];
   int kind[$];
   int run;

   bit         e_bv[512], e_ps[512], e_pe[512], e_se[512], e_st[512];
   logic [7:0] e_byte[512];
   int         e_cnt;
   bit         e_al;
   int         first_bv;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void put(input bit b, input int k);
      dec.push_back(b);
      kind.push_back(k);
      if (b) run++; else run = 0;
   endfunction

   function automatic void new_pkt(input bit good_sync);
      dec.delete();
      kind.delete();
      run = 0;
      for (int i = 0; i < 6; i++) put(1'b0, 0);
      put(good_sync ? 1'b0 : 1'b1, 0);
      put(1'b1, 0);
   endfunction

   function automatic void add_bit(input bit b);
      put(b, 1);
      if (run == 6) put(1'b0, 2);
   endfunction

   function automatic void add_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) add_bit(v[i]);
   endfunction

   function automatic void build_exp();
      int n, np, nbytes;
      logic [7:0] acc;
      bit sync_ok;
      n = dec.size();
      for (int i = 0; i < 512; i++) begin
         e_bv[i] = 0; e_ps[i] = 0; e_pe[i] = 0; e_se[i] = 0; e_st[i] = 0;
         e_byte[i] = 8'h00;
      end
      e_cnt = 0; e_al = 0; first_bv = -1;
      sync_ok = 1;
      for (int i = 0; i < 8; i++)
         if (dec[i] != (i == 7)) sync_ok = 0;
      // Strobe for the sample presented in cycle i appears in cycle i+3.
      if (!sync_ok) begin
         e_se[10] = 1;
         return;
      end
      e_ps[10] = 1;
      acc = 8'h00; np = 0; nbytes = 0;
      for (int i = 8; i < n; i++) begin
         if (kind[i] == 3) begin
            e_st[i + 3] = 1;
            return;
         end
         if (kind[i] == 1) begin
            acc[np % 8] = dec[i];
            np++;
            if (np % 8 == 0) begin
               e_bv[i + 3]   = 1;
               e_byte[i + 3] = acc;
               nbytes++;
               if (first_bv < 0) first_bv = i + 3;
            end
         end
      end
      // Two SE0 samples follow the data, done comes after them.
      e_pe[n + 3] = 1;
      e_cnt = (nbytes > MAXB) ? MAXB : nbytes;
      e_al  = (np % 8) != 0;
   endfunction

   task automatic drive_idle();
      rx.bstr = 1'b1; rx.bstr_ready = 1'b0; rx.done = 1'b0;
   endtask

   task automatic idle(input int cycles);
      drive_idle();
      repeat (cycles) begin
         @(posedge clk); #1;
         chk("idle_quiet", 32'({rx.byte_valid, rx.pkt_start, rx.pkt_end, rx.sync_err, rx.stuff_err}), 32'd0);
      end
   endtask

   // Drives the built packet; with do_rst the reset is pulsed two cycles
   // after the first byte strobe and the rest of the packet is abandoned.
   task automatic send(input bit do_rst);
      int n, c, rst_at;
      logic level;
      build_exp();
      n = dec.size();
      rst_at = do_rst ? first_bv + 2 : -1;
      level = 1'b1;
      for (int r = 0; r <= n + 6; r++) begin
         if (r < n) begin
            if (!dec[r]) level = ~level;
            rx.bstr = level; rx.bstr_ready = 1'b1; rx.done = 1'b0;
         end else if (r < n + 2) begin
            rx.bstr = 1'b0; rx.bstr_ready = 1'b1; rx.done = 1'b0;
         end else if (r == n + 2) begin
            rx.bstr = 1'b1; rx.bstr_ready = 1'b0; rx.done = 1'b1;
         end else begin
            drive_idle();
         end
         @(posedge clk); #1;
         c = r + 1;
         chk("byte_valid", 32'(rx.byte_valid), 32'(e_bv[c]));
         chk("pkt_start",  32'(rx.pkt_start),  32'(e_ps[c]));
         chk("pkt_end",    32'(rx.pkt_end),    32'(e_pe[c]));
         chk("sync_err",   32'(rx.sync_err),   32'(e_se[c]));
         chk("stuff_err",  32'(rx.stuff_err),  32'(e_st[c]));
         if (e_bv[c]) chk("byte_out", 32'(rx.byte_out), 32'(e_byte[c]));
         if (e_pe[c]) begin
            chk("byte_count", 32'(rx.byte_count), 32'(e_cnt));
            chk("align_err",  32'(rx.align_err),  32'(e_al));
         end
         if (c == rst_at) begin
            rst_b = 1'b0;
            #1;
            chk("rst_mid_outputs", 32'({rx.byte_out, rx.byte_count, rx.align_err, rx.byte_valid,
                rx.pkt_start, rx.pkt_end, rx.sync_err, rx.stuff_err}), 32'd0);
            drive_idle();
            @(negedge clk);
            rst_b = 1'b1;
            return;
         end
      end
   endtask

   task automatic rand_pkt(input int nbytes, input int extra);
      new_pkt(1'b1);
      for (int i = 0; i < nbytes; i++) add_byte(8'($urandom));
      for (int i = 0; i < extra; i++) add_bit(1'($urandom));
   endtask

   initial begin
      drive_idle();
      rst_b = 1'b0;
      #12;
      chk("reset_outputs", 32'({rx.byte_out, rx.byte_count, rx.align_err, rx.byte_valid,
          rx.pkt_start, rx.pkt_end, rx.sync_err, rx.stuff_err}), 32'd0);
      rst_b = 1'b1;
      idle(3);

      // clean token
      new_pkt(1'b1);
      add_byte(8'hE1); add_byte(8'h00); add_byte(8'h10);
      send(1'b0);
      idle(3);

      // all-ones payload forces stuff bits
      new_pkt(1'b1);
      add_byte(8'hFF); add_byte(8'hFF);
      send(1'b0);
      idle(3);

      // stuff violation, then a clean packet
      new_pkt(1'b1);
      add_byte(8'($urandom));
      add_bit(1'b0);
      for (int i = 0; i < 6; i++) put(1'b1, 1);
      put(1'b1, 3);
      for (int i = 0; i < 10; i++) put(1'($urandom), 4);
      send(1'b0);
      idle(3);
      rand_pkt(3, 0);
      send(1'b0);
      idle(3);

      // bad SYNC
      new_pkt(1'b0);
      add_byte(8'($urandom)); add_byte(8'($urandom));
      send(1'b0);
      idle(3);

      // misaligned EOP: 12 payload bits
      rand_pkt(1, 4);
      send(1'b0);
      idle(3);

      // reset mid-DATA, then a full packet
      rand_pkt(3, 0);
      send(1'b1);
      idle(3);
      rand_pkt(4, 0);
      send(1'b0);
      idle(3);

      // byte_count saturation
      rand_pkt(MAXB + 2, 0);
      send(1'b0);
      idle(3);

      // random packets, random alignment
      for (int k = 0; k < 8; k++) begin
         rand_pkt($urandom_range(0, 12), $urandom_range(0, 7));
         send(1'b0);
         idle($urandom_range(1, 4));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
